// File: rtl/mu0_pkg.sv
// Shared MU0 definitions: sequencer state encoding, phase codes and CPU status codes.
// Imported by the phase sequencer and by the CPU decoder.
package mu0_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_F_ADDR = 3'd1,
        ST_F_DATA = 3'd2,
        ST_E_ADDR = 3'd3,
        ST_E_DATA = 3'd4,
        ST_HALTED = 3'd5,
        ST_ERROR  = 3'd6
    } seq_state_t;

    localparam logic [1:0] PHASE_FETCH_ADDR = 2'd0;
    localparam logic [1:0] PHASE_FETCH_DATA = 2'd1;
    localparam logic [1:0] PHASE_EXEC_ADDR  = 2'd2;
    localparam logic [1:0] PHASE_EXEC_DATA  = 2'd3;

    localparam logic [2:0] STATUS_HALTED = 3'b100;

    // Non-phase states present code 0: the CPU only mutates state on codes 1 and 3.
    function automatic logic [1:0] phase_of(input seq_state_t s);
        logic [1:0] p;
        p = PHASE_FETCH_ADDR;
        case (s)
            ST_F_DATA: p = PHASE_FETCH_DATA;
            ST_E_ADDR: p = PHASE_EXEC_ADDR;
            ST_E_DATA: p = PHASE_EXEC_DATA;
            default:   p = PHASE_FETCH_ADDR;
        endcase
        return p;
    endfunction

    function automatic logic is_phase_state(input seq_state_t s);
        return (s == ST_F_ADDR) || (s == ST_F_DATA) ||
               (s == ST_E_ADDR) || (s == ST_E_DATA);
    endfunction

endpackage

// File: rtl/mu0_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous active-low clear.
module mu0_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mu0_phase_sequencer.sv
// MU0 phase sequencer: steps the CPU through fetch/exec address/data phases,
// inserts memory wait states, detects halt and wait timeouts, counts cycles.
module mu0_phase_sequencer
    import mu0_pkg::*;
#(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic             mem_ready,
    input  logic [2:0]       get_status,
    output logic [1:0]       flag,
    output logic             busy,
    output logic             halted,
    output logic             error,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    localparam int              WAIT_W    = $clog2(WAIT_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

    seq_state_t        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              one_shot_q, one_shot_d;
    // stop_q marks the F_ADDR visit after E_DATA as a halt-check that then returns to IDLE.
    logic              stop_q, stop_d;

    logic [1:0]        flag_q;
    logic              busy_q;
    logic              halted_q;
    logic              error_q;

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        one_shot_d = one_shot_q;
        stop_d     = stop_q;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d    = ST_F_ADDR;
                    wait_d     = '0;
                    one_shot_d = 1'b0;
                    stop_d     = 1'b0;
                end else if (step) begin
                    state_d    = ST_F_ADDR;
                    wait_d     = '0;
                    one_shot_d = 1'b1;
                    stop_d     = 1'b0;
                end
            end

            ST_F_ADDR: begin
                // The CPU's STP status lags E_DATA by one cycle, so halt is sampled
                // on the first F_ADDR cycle and outranks mem_ready.
                if ((wait_q == '0) && (get_status == STATUS_HALTED)) begin
                    state_d = ST_HALTED;
                end else if (stop_q) begin
                    state_d = ST_IDLE;
                    stop_d  = 1'b0;
                end else if (mem_ready) begin
                    state_d = ST_F_DATA;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ST_ERROR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            ST_F_DATA: begin
                state_d = ST_E_ADDR;
                wait_d  = '0;
            end

            ST_E_ADDR: begin
                if (mem_ready) begin
                    state_d = ST_E_DATA;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ST_ERROR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            ST_E_DATA: begin
                // run is only consulted here, so an instruction always completes.
                state_d    = ST_F_ADDR;
                wait_d     = '0;
                stop_d     = one_shot_q || !run;
                one_shot_d = 1'b0;
            end

            ST_HALTED: state_d = ST_HALTED;
            ST_ERROR:  state_d = ST_ERROR;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            wait_q     <= '0;
            one_shot_q <= 1'b0;
            stop_q     <= 1'b0;
            flag_q     <= PHASE_FETCH_ADDR;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            one_shot_q <= one_shot_d;
            stop_q     <= stop_d;
            flag_q     <= phase_of(state_d);
            busy_q     <= is_phase_state(state_d);
            halted_q   <= (state_d == ST_HALTED);
            error_q    <= (state_d == ST_ERROR);
        end
    end

    assign flag   = flag_q;
    assign busy   = busy_q;
    assign halted = halted_q;
    assign error  = error_q;

    mu0_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (busy_q),
        .count (cycle_count)
    );

    mu0_sat_counter #(.W(CNT_W)) u_instr_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (state_q == ST_E_DATA),
        .count (instr_count)
    );

endmodule

// File: tb/tb_mu0_phase_sequencer.sv
// Scoreboard bench for mu0_phase_sequencer: per-cycle expected phase outputs are
// queued as stimulus is applied and compared after each rising edge.
module tb_mu0_phase_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        mem_ready = 1'b0;
    logic [2:0]  get_status = 3'b000;
    logic [1:0]  flag;
    logic        busy;
    logic        halted;
    logic        error;
    logic [31:0] cycle_count;
    logic [31:0] instr_count;

    mu0_phase_sequencer #(.WAIT_LIMIT(16), .CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .step        (step),
        .mem_ready   (mem_ready),
        .get_status  (get_status),
        .flag        (flag),
        .busy        (busy),
        .halted      (halted),
        .error       (error),
        .cycle_count (cycle_count),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    // Expected {flag, busy, halted, error}
    localparam logic [4:0] X_IDLE = 5'b00_1_0_0 & 5'b00_0_0_0;
    localparam logic [4:0] X_FA   = 5'b00_1_0_0;
    localparam logic [4:0] X_FD   = 5'b01_1_0_0;
    localparam logic [4:0] X_EA   = 5'b10_1_0_0;
    localparam logic [4:0] X_ED   = 5'b11_1_0_0;
    localparam logic [4:0] X_HALT = 5'b00_0_1_0;
    localparam logic [4:0] X_ERR  = 5'b00_0_0_1;

    int         n_chk  = 0;
    int         n_fail = 0;
    int         cyc    = 0;
    logic [4:0] exp_q[$];
    logic [4:0] mon_e;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk($sformatf("cyc%0d flag/busy/halted/error", cyc),
                {59'd0, flag, busy, halted, error}, {59'd0, mon_e});
        end
    end

    // Apply mem_ready for the next edge, queue the outputs expected after it.
    task automatic cyc_step(input logic mr, input logic [4:0] e);
        mem_ready = mr;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic chk_cnt(input string tag, input int ei, input int ec);
        chk({tag, " instr_count"}, {32'd0, instr_count}, 64'(ei));
        chk({tag, " cycle_count"}, {32'd0, cycle_count}, 64'(ec));
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        cyc_step(1'b1, X_IDLE);
        rst = 1'b1;
        chk_cnt(tag, 0, 0);
    endtask

    // Drives one instruction starting on the first F_ADDR cycle, ending in E_DATA.
    task automatic do_instr(input int wf, input int we);
        for (int i = 0; i < wf; i++) cyc_step(1'b0, X_FA);
        cyc_step(1'b1, X_FD);
        cyc_step(1'b0, X_EA);
        for (int i = 0; i < we; i++) cyc_step(1'b0, X_EA);
        cyc_step(1'b1, X_ED);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Free run with memory always ready: 4 cycles per instruction.
        run = 1'b1;
        do_reset("reset1");
        cyc_step(1'b1, X_FA);
        for (int n = 0; n < 3; n++) begin
            do_instr(0, 0);
            cyc_step(1'b1, X_FA);
        end
        chk_cnt("run3", 3, 12);

        // Wait states in both address phases; data phases stay single-cycle.
        do_reset("reset2");
        cyc_step(1'b0, X_FA);
        do_instr(1, 1);
        cyc_step(1'b0, X_FA);
        do_instr(1, 1);
        cyc_step(1'b0, X_FA);
        do_instr(2, 2);
        cyc_step(1'b0, X_FA);
        chk_cnt("waits", 3, 20);

        // F_ADDR timeout after 16 low cycles; ERROR ignores everything but reset.
        do_reset("reset3");
        cyc_step(1'b0, X_FA);
        for (int i = 0; i < 15; i++) cyc_step(1'b0, X_FA);
        cyc_step(1'b0, X_ERR);
        chk_cnt("timeout", 0, 16);
        run = 1'b0; step = 1'b1;
        cyc_step(1'b1, X_ERR);
        step = 1'b0; run = 1'b1;
        cyc_step(1'b1, X_ERR);
        cyc_step(1'b0, X_ERR);
        run = 1'b0;
        cyc_step(1'b1, X_ERR);
        chk_cnt("err_hold", 0, 16);

        // Ready in the 16th wait cycle is accepted; E_ADDR times out the same way.
        run = 1'b1;
        do_reset("reset4");
        cyc_step(1'b0, X_FA);
        for (int i = 0; i < 15; i++) cyc_step(1'b0, X_FA);
        cyc_step(1'b1, X_FD);
        cyc_step(1'b0, X_EA);
        for (int i = 0; i < 15; i++) cyc_step(1'b0, X_EA);
        cyc_step(1'b0, X_ERR);
        chk_cnt("e_timeout", 0, 33);

        // Halt status appears in the F_ADDR cycle after the 2nd E_DATA.
        do_reset("reset5");
        cyc_step(1'b1, X_FA);
        do_instr(0, 0);
        cyc_step(1'b1, X_FA);
        do_instr(0, 0);
        cyc_step(1'b1, X_FA);
        get_status = 3'b100;
        cyc_step(1'b1, X_HALT);
        get_status = 3'b000;
        step = 1'b1;
        cyc_step(1'b1, X_HALT);
        step = 1'b0;
        cyc_step(1'b1, X_HALT);
        chk_cnt("halt", 2, 9);

        // Single step; a step pulse during E_ADDR is ignored.
        run = 1'b0;
        do_reset("reset6");
        cyc_step(1'b1, X_IDLE);
        step = 1'b1;
        cyc_step(1'b0, X_FA);
        step = 1'b0;
        cyc_step(1'b1, X_FD);
        cyc_step(1'b0, X_EA);
        step = 1'b1;
        cyc_step(1'b0, X_EA);
        step = 1'b0;
        cyc_step(1'b1, X_ED);
        cyc_step(1'b1, X_FA);
        cyc_step(1'b1, X_IDLE);
        cyc_step(1'b1, X_IDLE);
        chk_cnt("step", 1, 6);

        // Halt detected on the halt-check cycle of a single step.
        do_reset("reset7");
        step = 1'b1;
        cyc_step(1'b1, X_FA);
        step = 1'b0;
        do_instr(0, 0);
        cyc_step(1'b1, X_FA);
        get_status = 3'b100;
        cyc_step(1'b1, X_HALT);
        get_status = 3'b000;
        cyc_step(1'b1, X_HALT);
        chk_cnt("step_halt", 1, 5);

        // run+step together runs continuously; run drop mid-instruction 4 completes it.
        do_reset("reset8");
        run = 1'b1; step = 1'b1;
        cyc_step(1'b1, X_FA);
        step = 1'b0;
        for (int n = 0; n < 3; n++) begin
            do_instr(0, 0);
            cyc_step(1'b1, X_FA);
        end
        cyc_step(1'b1, X_FD);
        run = 1'b0;
        cyc_step(1'b1, X_EA);
        cyc_step(1'b1, X_ED);
        cyc_step(1'b1, X_FA);
        cyc_step(1'b1, X_IDLE);
        cyc_step(1'b1, X_IDLE);
        chk_cnt("run_drop", 4, 17);

        // Reset asserted in E_ADDR wins over mem_ready.
        run = 1'b1;
        cyc_step(1'b1, X_FA);
        cyc_step(1'b1, X_FD);
        cyc_step(1'b1, X_EA);
        chk_cnt("pre_rst", 4, 19);
        rst = 1'b0;
        cyc_step(1'b1, X_IDLE);
        rst = 1'b1;
        chk_cnt("mid_rst", 0, 0);

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
